sched_lanes_rx: RTL and testbench

Four-lane receive scheduler sitting downstream of the PHY receiver's byte-unstriping outputs (four 8-bit lanes with per-lane valids). Buffers each lane in a small FIFO and merges the lanes into one byte stream with a valid/ready handshake toward the link layer. Default is strict lane rotation 0→1→2→3 to restore the original striped byte order; a compile-time option makes it a work-conserving round-robin arbiter.

---
 rtl/sched_lanes_pkg.sv | 14 +
 rtl/sched_lanes_rx_lane_fifo.sv | 73 +++++++
 rtl/sched_lanes_rx.sv | 107 ++++++++++
 tb/tb_sched_lanes_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_lanes_pkg.sv
// Shared types and constants for the four-lane receive scheduler.
// Lane indices are 2 bits so rotation arithmetic wraps 3 -> 0 for free.
package sched_lanes_pkg;

    localparam int NUM_LANES = 4;
    localparam int BYTE_W    = 8;

    typedef logic [1:0] lane_idx_t;

    function automatic lane_idx_t next_lane(input lane_idx_t cur);
        return cur + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/sched_lanes_rx_lane_fifo.sv
// Per-lane byte FIFO with occupancy counter and sticky overflow flag.
// A push into a full FIFO is kept only when the same lane is popped that cycle.
module lane_fifo
    import sched_lanes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_4f,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              overflow_reg;

    logic do_pop;
    logic do_push;
    logic drop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_CNT);
    assign dout     = mem[rd_ptr_reg];
    assign overflow = overflow_reg;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk_4f) begin
        if (do_push && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sched_lanes_rx.sv
// Four-lane receive scheduler: per-lane FIFOs merged into one byte stream.
// Strict 0->1->2->3 rotation by default; define RR_SKIP_EN for work-conserving round-robin.
module sched_lanes_rx
    import sched_lanes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_4f,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in0,
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic [BYTE_W-1:0] in3,
    input  logic              val_in0,
    input  logic              val_in1,
    input  logic              val_in2,
    input  logic              val_in3,
    input  logic              ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_sel,
    output logic [3:0]        full,
    output logic [3:0]        overflow
);

    logic [BYTE_W-1:0]    lane_din  [NUM_LANES];
    logic [BYTE_W-1:0]    lane_dout [NUM_LANES];
    logic [NUM_LANES-1:0] lane_val;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_empty;

    lane_idx_t         ptr_reg;
    logic [BYTE_W-1:0] data_out_reg;
    lane_idx_t         lane_sel_reg;
    logic              valid_out_reg;

    logic      load_en;
    logic      grant_valid;
    lane_idx_t grant_lane;

    assign lane_din[0] = in0;
    assign lane_din[1] = in1;
    assign lane_din[2] = in2;
    assign lane_din[3] = in3;
    assign lane_val    = {val_in3, val_in2, val_in1, val_in0};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_pop[gi] = grant_valid && (grant_lane == lane_idx_t'(gi));

            lane_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk_4f   (clk_4f),
                .rst      (rst),
                .push     (lane_val[gi]),
                .din      (lane_din[gi]),
                .pop      (lane_pop[gi]),
                .dout     (lane_dout[gi]),
                .empty    (lane_empty[gi]),
                .full     (full[gi]),
                .overflow (overflow[gi])
            );
        end
    endgenerate

    // A held byte that is not accepted freezes the output and blocks all pops.
    assign load_en = !valid_out_reg || ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = ptr_reg;
`ifdef RR_SKIP_EN
        // Descending scan so the nearest non-empty lane after ptr wins last.
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (!lane_empty[ptr_reg + lane_idx_t'(k)]) begin
                grant_valid = load_en;
                grant_lane  = ptr_reg + lane_idx_t'(k);
            end
        end
`else
        grant_valid = load_en && !lane_empty[ptr_reg];
`endif
    end

    always_ff @(posedge clk_4f) begin
        if (rst) begin
            ptr_reg       <= '0;
            data_out_reg  <= '0;
            lane_sel_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else if (grant_valid) begin
            data_out_reg  <= lane_dout[grant_lane];
            lane_sel_reg  <= grant_lane;
            valid_out_reg <= 1'b1;
            ptr_reg       <= next_lane(grant_lane);
        end else if (load_en) begin
            valid_out_reg <= 1'b0;
        end
    end

    assign data_out  = data_out_reg;
    assign lane_sel  = lane_sel_reg;
    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_sched_lanes_rx.sv
// Directed self-checking bench for sched_lanes_rx (DEPTH = 4).
module tb_sched_lanes_rx;

    logic       clk_4f;
    logic       rst;
    logic [7:0] in0, in1, in2, in3;
    logic       val_in0, val_in1, val_in2, val_in3;
    logic       ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_sel;
    logic [3:0] full;
    logic [3:0] overflow;

    int total = 0;
    int bad   = 0;

    sched_lanes_rx #(.DEPTH(4)) dut (
        .clk_4f    (clk_4f),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .val_in0   (val_in0),
        .val_in1   (val_in1),
        .val_in2   (val_in2),
        .val_in3   (val_in3),
        .ready     (ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_sel  (lane_sel),
        .full      (full),
        .overflow  (overflow)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        val_in0 = v[0]; val_in1 = v[1]; val_in2 = v[2]; val_in3 = v[3];
        in0 = b0; in1 = b1; in2 = b2; in3 = b3;
    endtask

    task automatic idle();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] l);
        check({tag, ".valid"}, 32'(valid_out), 32'(v));
        if (v) begin
            check({tag, ".data"}, 32'(data_out), 32'(d));
            check({tag, ".lane"}, 32'(lane_sel), 32'(l));
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b1;
        drive(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step();
        step();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        ready = 1'b1;
        idle();

        // Reset with push strobes high: nothing may be captured.
        do_reset();
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.data", 32'(data_out), 32'h00);
        check("rst.lane", 32'(lane_sel), 32'd0);
        check("rst.ovf", 32'(overflow), 32'h0);
        check("rst.full", 32'(full), 32'h0);
        step();
        check("rst.nocapture", 32'(valid_out), 32'd0);

        // Ordered unstripe, full throughput, one bubble after the push edge.
        drive(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        step();
        idle();
        expect_out("ord.bubble", 1'b0, 8'h00, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out($sformatf("ord.%0d", i), 1'b1, 8'(8'h10 + i), 2'(i));
        end
        step();
        expect_out("ord.end", 1'b0, 8'h00, 2'd0);

        // Strict stall: lane 0 empty blocks lanes 1..3.
        drive(4'b1110, 8'h00, 8'h21, 8'h22, 8'h23);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("stall.wait%0d", i), 1'b0, 8'h00, 2'd0);
        end
        drive(4'b0001, 8'hA0, 8'h00, 8'h00, 8'h00);
        step();
        idle();
        expect_out("stall.nobypass", 1'b0, 8'h00, 2'd0);
        step();
        expect_out("stall.l0", 1'b1, 8'hA0, 2'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            expect_out($sformatf("stall.l%0d", i), 1'b1, 8'(8'h20 + i), 2'(i));
        end
        step();
        expect_out("stall.end", 1'b0, 8'h00, 2'd0);

        // Backpressure: output frozen for 5 cycles, then resumes without loss.
        drive(4'b1111, 8'h30, 8'h31, 8'h32, 8'h33);
        step();
        idle();
        ready = 1'b0;
        step();
        expect_out("bp.load", 1'b1, 8'h30, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("bp.hold%0d", i), 1'b1, 8'h30, 2'd0);
        end
        ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            expect_out($sformatf("bp.res%0d", i), 1'b1, 8'(8'h30 + i), 2'(i));
        end
        step();
        expect_out("bp.end", 1'b0, 8'h00, 2'd0);

        // Overflow on lane 2 with the output stalled.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 8'h00, 8'h00, 8'(8'h40 + i), 8'h00);
            step();
            if (i == 3) begin
                check("ovf.full4", 32'(full), 32'h4);
                check("ovf.none4", 32'(overflow), 32'h0);
            end
        end
        idle();
        check("ovf.full5", 32'(full), 32'h4);
        check("ovf.flag", 32'(overflow), 32'h4);
        check("ovf.novalid", 32'(valid_out), 32'd0);
        ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            drive(4'b1011, 8'(8'h60 + r), 8'(8'h70 + r), 8'h00, 8'(8'h80 + r));
            step();
            idle();
            expect_out($sformatf("ovf.r%0d.gap", r), 1'b0, 8'h00, 2'd0);
            step();
            expect_out($sformatf("ovf.r%0d.l0", r), 1'b1, 8'(8'h60 + r), 2'd0);
            step();
            expect_out($sformatf("ovf.r%0d.l1", r), 1'b1, 8'(8'h70 + r), 2'd1);
            step();
            expect_out($sformatf("ovf.r%0d.l2", r), 1'b1, 8'(8'h40 + r), 2'd2);
            step();
            expect_out($sformatf("ovf.r%0d.l3", r), 1'b1, 8'(8'h80 + r), 2'd3);
        end
        // Dropped fifth byte must not appear: lane 2 is now empty and stalls.
        drive(4'b0011, 8'h90, 8'h91, 8'h00, 8'h00);
        step();
        idle();
        step();
        expect_out("drop.l0", 1'b1, 8'h90, 2'd0);
        step();
        expect_out("drop.l1", 1'b1, 8'h91, 2'd1);
        step();
        expect_out("drop.l2empty", 1'b0, 8'h00, 2'd0);
        check("drop.full", 32'(full), 32'h0);
        check("drop.ovfsticky", 32'(overflow), 32'h4);

        // Reset mid-transfer discards held and buffered bytes and clears overflow.
        drive(4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        step();
        idle();
        step();
        step();
        do_reset();
        check("mid.valid", 32'(valid_out), 32'd0);
        check("mid.data", 32'(data_out), 32'h00);
        check("mid.ovf", 32'(overflow), 32'h0);
        step();
        step();
        check("mid.flushed", 32'(valid_out), 32'd0);

`ifdef RR_SKIP_EN
        drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h55);
        step();
        idle();
        step();
        expect_out("rr.skip", 1'b1, 8'h55, 2'd3);
        drive(4'b0011, 8'h77, 8'h66, 8'h00, 8'h00);
        step();
        idle();
        expect_out("rr.gap", 1'b0, 8'h00, 2'd0);
        step();
        expect_out("rr.l0", 1'b1, 8'h77, 2'd0);
        step();
        expect_out("rr.l1", 1'b1, 8'h66, 2'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
